// File: rtl/jstk_spi_responder_pkg.sv
// jstk_pkg: shared FSM states, frame constants and tx word packing for the joystick responder
package jstk_pkg;
  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
  localparam int FRAME_BITS = 40;
  localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;
  function automatic logic [FRAME_BITS-1:0] pack_tx(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
  endfunction
endpackage

// File: rtl/jstk_spi_responder_if.sv
// jstk_spi_responder_if: SPI pins between the joystick master and this responder
interface jstk_spi_responder_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  modport master (output sclk, ss_n, mosi, input miso, miso_oe);
  modport slave (input sclk, ss_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/jstk_spi_responder_sync_edge.sv
// sync_edge: multi-flop synchronizer with registered level and single-cycle rise/fall strobes
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  // clearing to 0 means a low ss_n after reset never yields a fall strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      level <= chain[STAGES-1];
      rise <= chain[STAGES-1] & ~level;
      fall <= ~chain[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: mode-0 SPI slave emulating the PmodJSTK position/button/LED link
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  jstk_spi_responder_if.slave        spi,
  input  logic [9:0]                 x_pos,
  input  logic [9:0]                 y_pos,
  input  logic [2:0]                 btn,
  output logic [1:0]                 led,
  output logic                       frame_done,
  output logic                       frame_err
);
  localparam int NBITS = 8 * NUM_BYTES;
  localparam int CW = $clog2(NBITS + 1);
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic [3:0] unused;
  state_t state;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [7:0] byte0, byte_nx;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic done_nx;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk), .level(unused[0]), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst(rst), .d(spi.ss_n), .level(unused[1]), .rise(ss_rise), .fall(ss_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .d(spi.mosi), .level(mosi_s), .rise(unused[2]), .fall(unused[3])
  );
  // only the command byte matters, so capture just the first eight received bits
  always_comb begin
    cnt_nx = bit_cnt + CW'(sclk_rise);
    byte_nx = (sclk_rise && bit_cnt < CW'(8)) ? {byte0[6:0], mosi_s} : byte0;
    done_nx = cnt_nx == CW'(NBITS);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_shift <= '0;
      byte0 <= '0;
      bit_cnt <= '0;
      spi.miso <= 1'b0;
      spi.miso_oe <= 1'b0;
      led <= 2'b00;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (ss_fall) begin
          tx_shift <= pack_tx(x_pos, y_pos, btn);
          spi.miso <= x_pos[7];
          spi.miso_oe <= 1'b1;
          bit_cnt <= '0;
          byte0 <= '0;
          state <= XFER;
        end
        XFER: if (ss_rise) begin
          frame_done <= done_nx;
          frame_err <= ~done_nx;
          if (done_nx && byte_nx[7:2] == LED_CMD_PREFIX) led <= byte_nx[1:0];
          spi.miso <= 1'b0;
          spi.miso_oe <= 1'b0;
          state <= IDLE;
        end else if (sclk_rise) begin
          bit_cnt <= cnt_nx;
          byte0 <= byte_nx;
          if (done_nx) begin
            spi.miso <= 1'b0;
            state <= HOLD;
          end
        end else if (sclk_fall && bit_cnt != '0) begin
          // the first bit stays on miso until the master has sampled it
          tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
          spi.miso <= tx_shift[FRAME_BITS-2];
        end
        HOLD: if (ss_rise) begin
          frame_done <= 1'b1;
          if (byte0[7:2] == LED_CMD_PREFIX) led <= byte0[1:0];
          spi.miso_oe <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed frames against a byte-level model of the joystick responder
module tb_jstk_spi_responder;
  localparam int HALF = 10;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] x_pos, y_pos;
  logic [2:0] btn;
  logic [1:0] led;
  logic frame_done, frame_err;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic check_en = 1'b0;
  logic [1:0] exp_led = 2'b00;
  logic exp_oe = 1'b0;
  logic [7:0] got [5];
  jstk_spi_responder_if spi ();
  jstk_spi_responder #(.SYNC_STAGES(SYNC), .NUM_BYTES(5)) dut (
    .clk(clk), .rst(rst), .spi(spi), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
    .led(led), .frame_done(frame_done), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // steady-state compare against the model whenever no transition is in flight
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (check_en) begin
      chk("led", 32'(led), 32'(exp_led));
      chk("miso_oe", 32'(spi.miso_oe), 32'(exp_oe));
      chk("pulse_exclusive", 32'(frame_done & frame_err), 32'd0);
      if (!exp_oe) chk("idle_miso", 32'(spi.miso), 32'd0);
    end
  end
  task automatic frame(input logic [7:0] b0, input int nbits, input int xchg_at, input int rst_at);
    logic [7:0] eb [5];
    logic aborted;
    logic exp_bit;
    int d0, e0;
    aborted = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    eb[0] = 8'(x_pos % 256);
    eb[1] = 8'(x_pos / 256);
    eb[2] = 8'(y_pos % 256);
    eb[3] = 8'(y_pos / 256);
    eb[4] = 8'(btn);
    for (int k = 0; k < 5; k++) got[k] = 8'h00;
    spi.ss_n = 1'b0;
    check_en = 1'b0;
    cyc(SYNC + 3);
    exp_oe = 1'b1;
    check_en = 1'b1;
    cyc(5);
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = (i < 8) ? b0[7-i] : 1'b0;
      cyc(HALF);
      spi.sclk = 1'b1;
      exp_bit = (aborted || i >= 40) ? 1'b0 : eb[i/8][7-i%8];
      chk("miso_bit", 32'(spi.miso), 32'(exp_bit));
      if (i < 40) got[i/8][7-i%8] = spi.miso;
      if (i + 1 == xchg_at) x_pos = 10'h000;
      if (i + 1 == rst_at) begin
        check_en = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        aborted = 1'b1;
        exp_led = 2'b00;
        exp_oe = 1'b0;
        cyc(3);
        check_en = 1'b1;
        cyc(HALF - 5);
      end else cyc(HALF);
      spi.sclk = 1'b0;
    end
    cyc(HALF);
    spi.ss_n = 1'b1;
    check_en = 1'b0;
    cyc(SYNC + 3);
    if (!aborted && nbits >= 40 && b0[7:2] == 6'b100000) exp_led = b0[1:0];
    exp_oe = 1'b0;
    cyc(2);
    check_en = 1'b1;
    chk("frame_done_count", 32'(done_cnt - d0), 32'(!aborted && nbits >= 40));
    chk("frame_err_count", 32'(err_cnt - e0), 32'(!aborted && nbits < 40));
    spi.mosi = 1'b0;
    cyc(10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    spi.sclk = 1'b0;
    spi.ss_n = 1'b1;
    spi.mosi = 1'b0;
    x_pos = 10'h2A5;
    y_pos = 10'h1C3;
    btn = 3'b101;
    cyc(4);
    chk("reset_miso", 32'(spi.miso), 32'd0);
    chk("reset_miso_oe", 32'(spi.miso_oe), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    cyc(8);
    check_en = 1'b1;
    frame(8'h81, 40, -1, -1);
    chk("basic_byte0", 32'(got[0]), 32'hA5);
    chk("basic_byte1", 32'(got[1]), 32'h02);
    chk("basic_byte2", 32'(got[2]), 32'hC3);
    chk("basic_byte3", 32'(got[3]), 32'h01);
    chk("basic_byte4", 32'(got[4]), 32'h05);
    chk("basic_led", 32'(led), 32'h1);
    frame(8'h41, 40, -1, -1);
    chk("badcmd_byte0", 32'(got[0]), 32'hA5);
    chk("badcmd_byte4", 32'(got[4]), 32'h05);
    chk("badcmd_led", 32'(led), 32'h1);
    frame(8'h82, 17, -1, -1);
    chk("abort_led", 32'(led), 32'h1);
    chk("abort_err_total", 32'(err_cnt), 32'd1);
    chk("abort_done_total", 32'(done_cnt), 32'd2);
    frame(8'h83, 40, -1, -1);
    chk("after_abort_led", 32'(led), 32'h3);
    frame(8'h80, 48, -1, -1);
    chk("overclock_led", 32'(led), 32'h0);
    chk("overclock_done_total", 32'(done_cnt), 32'd4);
    frame(8'h81, 40, 8, -1);
    chk("xchg_byte0", 32'(got[0]), 32'hA5);
    chk("xchg_byte1", 32'(got[1]), 32'h02);
    chk("xchg_byte2", 32'(got[2]), 32'hC3);
    x_pos = 10'h2A5;
    frame(8'h82, 40, -1, 20);
    chk("reset_frame_led", 32'(led), 32'h0);
    chk("reset_frame_done_total", 32'(done_cnt), 32'd5);
    chk("reset_frame_err_total", 32'(err_cnt), 32'd1);
    frame(8'h83, 40, -1, -1);
    chk("post_reset_byte0", 32'(got[0]), 32'hA5);
    chk("post_reset_byte3", 32'(got[3]), 32'h01);
    chk("post_reset_led", 32'(led), 32'h3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
